// File: rtl/fir_mac_sequencer.sv
// Address/strobe sequencer for a single shared FIR multiply-accumulate datapath.
// Loads coefficients, zero-fills the sample ring, then issues N MAC cycles per input sample.
module fir_mac_sequencer #(
  parameter int unsigned MAX_TAPS = 256,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MAC_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic [7:0]        n_taps,
  input  logic              coeff_valid,
  output logic              coeff_ready,
  output logic              coeff_we,
  output logic [ADDR_W-1:0] coeff_waddr,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_waddr,
  output logic              data_zero,
  output logic [ADDR_W-1:0] rd_data_addr,
  output logic [ADDR_W-1:0] rd_coeff_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              result_valid,
  output logic              busy,
  output logic              cfg_err
);

  localparam int unsigned CNT_W  = $clog2(MAX_TAPS + 1);
  localparam int unsigned DCNT_W = $clog2(MAC_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLOAD, S_CLEAR, S_WAIT, S_MAC, S_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d;
  logic [ADDR_W-1:0]   newest_q, newest_d;

  logic                coeff_ready_q, coeff_ready_d;
  logic                coeff_we_q, coeff_we_d;
  logic [ADDR_W-1:0]   coeff_waddr_q, coeff_waddr_d;
  logic                sample_ready_q, sample_ready_d;
  logic                data_we_q, data_we_d;
  logic [ADDR_W-1:0]   data_waddr_q, data_waddr_d;
  logic                data_zero_q, data_zero_d;
  logic [ADDR_W-1:0]   rd_data_addr_q, rd_data_addr_d;
  logic [ADDR_W-1:0]   rd_coeff_addr_q, rd_coeff_addr_d;
  logic                mac_en_q, mac_en_d;
  logic                mac_clr_q, mac_clr_d;
  logic                result_valid_q, result_valid_d;
  logic                busy_q, busy_d;
  logic                cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0]    newest_ext;
  logic [CNT_W-1:0]    rd_idx;

  // Circular read index: (newest - k) mod N without a divider.
  assign newest_ext = CNT_W'(newest_q);
  assign rd_idx     = (newest_ext >= k_q) ? (newest_ext - k_q) : (newest_ext + n_q - k_q);

  always_comb begin
    state_d         = state_q;
    n_d             = n_q;
    k_d             = k_q;
    dcnt_d          = dcnt_q;
    wptr_d          = wptr_q;
    newest_d        = newest_q;
    coeff_we_d      = 1'b0;
    coeff_waddr_d   = '0;
    data_we_d       = 1'b0;
    data_waddr_d    = '0;
    data_zero_d     = 1'b0;
    rd_data_addr_d  = '0;
    rd_coeff_addr_d = '0;
    mac_en_d        = 1'b0;
    mac_clr_d       = 1'b0;
    result_valid_d  = 1'b0;
    cfg_err_d       = 1'b0;

    if (halt && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      k_d     = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !halt) begin
            if ((n_taps == 8'd0) || (CNT_W'(n_taps) > CNT_W'(MAX_TAPS))) begin
              cfg_err_d = 1'b1;
            end else begin
              n_d     = CNT_W'(n_taps);
              k_d     = '0;
              state_d = S_CLOAD;
            end
          end
        end
        S_CLOAD: begin
          if (coeff_valid && coeff_ready_q) begin
            coeff_we_d    = 1'b1;
            coeff_waddr_d = ADDR_W'(k_q);
            if (k_q == n_q - CNT_W'(1)) begin
              k_d     = '0;
              state_d = S_CLEAR;
            end else begin
              k_d = k_q + CNT_W'(1);
            end
          end
        end
        S_CLEAR: begin
          if (k_q == n_q) begin
            k_d     = '0;
            wptr_d  = '0;
            state_d = S_WAIT;
          end else begin
            data_we_d    = 1'b1;
            data_zero_d  = 1'b1;
            data_waddr_d = ADDR_W'(k_q);
            k_d          = k_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // The write of the new sample and the first (k=0) MAC share a cycle.
          if (sample_valid && sample_ready_q) begin
            data_we_d       = 1'b1;
            data_waddr_d    = wptr_q;
            newest_d        = wptr_q;
            mac_en_d        = 1'b1;
            mac_clr_d       = 1'b1;
            rd_data_addr_d  = wptr_q;
            k_d             = CNT_W'(1);
            state_d         = S_MAC;
          end
        end
        S_MAC: begin
          if (k_q == n_q) begin
            k_d            = '0;
            dcnt_d         = DCNT_W'(1);
            result_valid_d = (MAC_LAT == 1);
            state_d        = S_DRAIN;
          end else begin
            mac_en_d        = 1'b1;
            rd_coeff_addr_d = ADDR_W'(k_q);
            rd_data_addr_d  = ADDR_W'(rd_idx);
            k_d             = k_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt_q == DCNT_W'(MAC_LAT)) begin
            dcnt_d  = '0;
            wptr_d  = (CNT_W'(wptr_q) == n_q - CNT_W'(1)) ? '0 : wptr_q + ADDR_W'(1);
            state_d = S_WAIT;
          end else begin
            result_valid_d = (dcnt_q == DCNT_W'(MAC_LAT - 1));
            dcnt_d         = dcnt_q + DCNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    coeff_ready_d  = (state_d == S_CLOAD);
    sample_ready_d = (state_d == S_WAIT);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      n_q             <= '0;
      k_q             <= '0;
      dcnt_q          <= '0;
      wptr_q          <= '0;
      newest_q        <= '0;
      coeff_ready_q   <= 1'b0;
      coeff_we_q      <= 1'b0;
      coeff_waddr_q   <= '0;
      sample_ready_q  <= 1'b0;
      data_we_q       <= 1'b0;
      data_waddr_q    <= '0;
      data_zero_q     <= 1'b0;
      rd_data_addr_q  <= '0;
      rd_coeff_addr_q <= '0;
      mac_en_q        <= 1'b0;
      mac_clr_q       <= 1'b0;
      result_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      cfg_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      k_q             <= k_d;
      dcnt_q          <= dcnt_d;
      wptr_q          <= wptr_d;
      newest_q        <= newest_d;
      coeff_ready_q   <= coeff_ready_d;
      coeff_we_q      <= coeff_we_d;
      coeff_waddr_q   <= coeff_waddr_d;
      sample_ready_q  <= sample_ready_d;
      data_we_q       <= data_we_d;
      data_waddr_q    <= data_waddr_d;
      data_zero_q     <= data_zero_d;
      rd_data_addr_q  <= rd_data_addr_d;
      rd_coeff_addr_q <= rd_coeff_addr_d;
      mac_en_q        <= mac_en_d;
      mac_clr_q       <= mac_clr_d;
      result_valid_q  <= result_valid_d;
      busy_q          <= busy_d;
      cfg_err_q       <= cfg_err_d;
    end
  end

  assign coeff_ready   = coeff_ready_q;
  assign coeff_we      = coeff_we_q;
  assign coeff_waddr   = coeff_waddr_q;
  assign sample_ready  = sample_ready_q;
  assign data_we       = data_we_q;
  assign data_waddr    = data_waddr_q;
  assign data_zero     = data_zero_q;
  assign rd_data_addr  = rd_data_addr_q;
  assign rd_coeff_addr = rd_coeff_addr_q;
  assign mac_en        = mac_en_q;
  assign mac_clr       = mac_clr_q;
  assign result_valid  = result_valid_q;
  assign busy          = busy_q;
  assign cfg_err       = cfg_err_q;

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Microprogram-style controller that sequences one shared multiply-accumulate datapath for the scalable FIR filter. Per run it loads N coefficients, zero-fills an N-entry circular sample buffer, then for each accepted input sample issues N MAC cycles with paired data/coefficient read addresses. It pulses result_valid when the accumulator holds y[n]. The block drives addresses and strobes only; the RAMs, multiplier and accumulator live in the datapath.

Parameters:
MAX_TAPS, 256, largest legal tap count; sizes the address counters.
ADDR_W, 8, width of all address outputs (clog2(MAX_TAPS)).
MAC_LAT, 2, cycles from a mac_en cycle until its product is in the accumulator; must be at least 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  IDLE only: latch n_taps and begin a run.
halt  in  1  abort run from any state.
n_taps  in  8  tap count N, sampled on start.
coeff_valid  in  1  coefficient word present on datapath bus.
coeff_ready  out  1  high in CLOAD.
coeff_we  out  1  write strobe to coefficient RAM.
coeff_waddr  out  ADDR_W  coefficient write address.
sample_valid  in  1  input sample present.
sample_ready  out  1  high in WAIT.
data_we  out  1  write strobe to sample RAM.
data_waddr  out  ADDR_W  sample write address.
data_zero  out  1  datapath writes 0 instead of input_data.
rd_data_addr  out  ADDR_W  sample RAM read address.
rd_coeff_addr  out  ADDR_W  coefficient RAM read address.
mac_en  out  1  accumulate the product this cycle.
mac_clr  out  1  with mac_en: load the product instead of adding it.
result_valid  out  1  one-cycle pulse: accumulator holds y[n].
busy  out  1  state not IDLE.
cfg_err  out  1  one-cycle pulse on an illegal start.

Behaviour:
- All outputs are registered. Reset (async) forces state IDLE, all outputs 0, and all counters and pointers 0.
- States: IDLE, CLOAD, CLEAR, WAIT, MAC, DRAIN.
- IDLE, start=1:
  - n_taps==0 or n_taps>MAX_TAPS: pulse cfg_err for 1 cycle, remain in IDLE.
  - Otherwise latch N = n_taps, k=0, go to CLOAD.
- CLOAD: coeff_ready=1. On each cycle with coeff_valid & coeff_ready:
  - Assert coeff_we with coeff_waddr=k, then k++.
  - Gaps (coeff_valid=0) do not advance k.
  - After the N-th handshake, go to CLEAR with k=0.
- CLEAR: N consecutive cycles of data_we=1, data_zero=1, data_waddr=k (0..N-1). Then wptr=0, go to WAIT.
- WAIT: sample_ready=1. On sample_valid, in the same cycle:
  - Assert data_we=1, data_zero=0, data_waddr=wptr.
  - Set newest=wptr, k=0, go to MAC.
- MAC: one cycle per k=0..N-1, each cycle driving:
  - mac_en=1.
  - mac_clr=(k==0).
  - rd_coeff_addr=k.
  - rd_data_addr=(newest-k) mod N, i.e. newest-k if newest>=k, else newest-k+N.
  - After k=N-1, go to DRAIN.
- DRAIN: wait MAC_LAT cycles with mac_en=0.
  - result_valid pulses exactly MAC_LAT cycles after the last mac_en cycle.
  - That same cycle: wptr = (wptr==N-1) ? 0 : wptr+1, return to WAIT.
- Timing: sample accepted at cycle T → mac_en at cycles T+1..T+N → result_valid at T+N+MAC_LAT. Sample period is N+MAC_LAT+1 cycles.
- sample_ready=0 outside WAIT; samples offered then are not accepted.
- halt (any non-IDLE state):
  - Next edge: IDLE with all strobes 0.
  - No result_valid for the in-flight sample; coefficients must be reloaded.
  - halt has priority over start in the same cycle.
- start outside IDLE is ignored.
- N=1: MAC is one cycle with rd_data_addr=0, wptr stays 0.
- Reset mid-run: immediate return to IDLE, outputs cleared asynchronously.

Test Plan:
- N=4, start, 4 coefficients back-to-back → coeff_we at coeff_waddr 0,1,2,3; then 4 cycles data_we/data_zero at addresses 0..3; sample_ready rises on the next cycle.
- First sample accepted at T → data_waddr=0; rd_data_addr 0,3,2,1 with rd_coeff_addr 0,1,2,3; mac_clr only at T+1; result_valid only at T+6 (MAC_LAT=2). With coeffs 1,2,3,4 and sample 5, datapath output is 5.
- Samples 2..5 → data_waddr 1,2,3,0; fifth-sample reads 0,3,2,1; second-sample reads 1,0,3,2. Impulse input yields outputs 1,2,3,4,0.
- coeff_valid toggling 1,0,1,0... → only handshake cycles advance coeff_waddr. start with n_taps=0 → single cfg_err pulse, busy stays 0, no strobes.
- halt at the 2nd MAC cycle → mac_en 0 next cycle, no result_valid, busy 0. Async reset mid-CLEAR → all outputs 0 before the next edge.
- N=1: every sample gives one mac_en with mac_clr=1, addresses 0/0, result_valid 3 cycles after acceptance.
